iic_slave: RTL and testbench

IIC_SLAVE -- requirements
Module: iic_slave

---
 rtl/iic_pkg.sv | 34 +++
 rtl/iic_slave_if.sv | 45 ++++
 rtl/iic_bus_sync.sv | 81 ++++++++
 rtl/iic_slave.sv | 272 +++++++++++++++++++++++++++
 tb/tb_iic_slave.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iic_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : iic_pkg
//  Description : Shared iic definitions for the target and the initiator:
//                controller state encoding and bit-phase timing constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package iic_pkg;

    // Controller states of the iic target
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_DEV_ADDR  = 4'd1,
        S_DEV_ACK   = 4'd2,
        S_REG_ADDR  = 4'd3,
        S_REG_ACK   = 4'd4,
        S_WDATA     = 4'd5,
        S_WDATA_ACK = 4'd6,
        S_RDATA     = 4'd7,
        S_RDATA_ACK = 4'd8
    } iic_state_e;

    // Data bits per byte on the wire (the ACK bit is the 9th)
    localparam int C_BITS_PER_BYTE = 8;
    // Width of the per-byte bit counter (must hold C_BITS_PER_BYTE)
    localparam int C_BIT_CNT_W     = 4;
    // System-clock cycles between a filtered SCL fall and any SDA change
    localparam int C_DRIVE_DLY     = 4;
    // Width of the SDA drive delay counter (must hold C_DRIVE_DLY)
    localparam int C_DLY_W         = 3;

endpackage : iic_pkg
`default_nettype wire

// File: rtl/iic_slave_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : iic_slave_if
//  Description : Register-side handshake between the iic target and the
//                register file it fronts.
//                reg_addr  - register address of the current access
//                reg_wdata - write data byte
//                reg_we    - one-cycle write strobe
//                reg_rd    - one-cycle read request
//                reg_rdata - read data, valid the cycle after reg_rd
//                busy      - bus transaction in progress (START to STOP)
//  Revision    : 1.0 - initial release
// ============================================================================
interface iic_slave_if;

    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       busy;

    // iic target side
    modport slave (
        output reg_addr,
        output reg_wdata,
        output reg_we,
        output reg_rd,
        output busy,
        input  reg_rdata
    );

    // register file side
    modport master (
        input  reg_addr,
        input  reg_wdata,
        input  reg_we,
        input  reg_rd,
        input  busy,
        output reg_rdata
    );

endinterface : iic_slave_if
`default_nettype wire

// File: rtl/iic_bus_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : iic_bus_sync
//  Description : Brings SCL/SDA into the I_clk domain through a 2-flop
//                synchronizer, then qualifies each level with a glitch filter
//                of C_FILT_LEN equal samples. SCL edges and START/STOP are
//                derived only from the filtered levels.
//  Ports       : I_clk, I_rst_n      - system clock, async active-low reset
//                I_scl, I_sda        - raw bus lines
//                O_scl, O_sda        - filtered levels
//                O_scl_rise/O_scl_fall - one-cycle filtered SCL edge strobes
//                O_start/O_stop      - one-cycle bus condition strobes
//  Revision    : 1.0 - initial release
// ============================================================================
module iic_bus_sync #(
    parameter int C_FILT_LEN = 3
) (
    input  wire logic I_clk,
    input  wire logic I_rst_n,
    input  wire logic I_scl,
    input  wire logic I_sda,
    output logic      O_scl,
    output logic      O_sda,
    output logic      O_scl_rise,
    output logic      O_scl_fall,
    output logic      O_start,
    output logic      O_stop
);

    logic [1:0]            r_scl_sync;
    logic [1:0]            r_sda_sync;
    logic [C_FILT_LEN-1:0] r_scl_hist;
    logic [C_FILT_LEN-1:0] r_sda_hist;
    logic                  r_scl_filt;
    logic                  r_sda_filt;
    logic                  r_scl_prev;
    logic                  r_sda_prev;

    // Everything presets to 1 so an idle (pulled-up) bus produces no edges.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_hist <= '1;
            r_sda_hist <= '1;
            r_scl_filt <= 1'b1;
            r_sda_filt <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], I_scl};
            r_sda_sync <= {r_sda_sync[0], I_sda};
            r_scl_hist <= (r_scl_hist << 1) | C_FILT_LEN'(r_scl_sync[1]);
            r_sda_hist <= (r_sda_hist << 1) | C_FILT_LEN'(r_sda_sync[1]);
            // A level is accepted only once the whole history agrees
            if (&r_scl_hist) begin
                r_scl_filt <= 1'b1;
            end else if (~|r_scl_hist) begin
                r_scl_filt <= 1'b0;
            end
            if (&r_sda_hist) begin
                r_sda_filt <= 1'b1;
            end else if (~|r_sda_hist) begin
                r_sda_filt <= 1'b0;
            end
            r_scl_prev <= r_scl_filt;
            r_sda_prev <= r_sda_filt;
        end
    end

    assign O_scl      = r_scl_filt;
    assign O_sda      = r_sda_filt;
    assign O_scl_rise = r_scl_filt & ~r_scl_prev;
    assign O_scl_fall = ~r_scl_filt & r_scl_prev;
    // SDA transitions count as bus conditions only while SCL is stably high
    assign O_start    = r_scl_filt & r_scl_prev & r_sda_prev & ~r_sda_filt;
    assign O_stop     = r_scl_filt & r_scl_prev & ~r_sda_prev & r_sda_filt;

endmodule : iic_bus_sync
`default_nettype wire

// File: rtl/iic_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : iic_slave
//  Description : iic target with 8-bit register addressing. A write carries
//                the register address followed by any number of data bytes;
//                a read returns bytes from the current address. The address
//                auto-increments after every data byte and wraps at 8'hFF.
//  Ports       : I_clk      - system clock
//                I_rst_n    - async active-low reset
//                I_iic_scl  - bus clock from the initiator (asynchronous)
//                IO_iic_sda - open-drain bus data (drives 0 or releases)
//                reg_if     - register-side handshake (slave modport)
//  Revision    : 1.0 - initial release
// ============================================================================
module iic_slave
    import iic_pkg::*;
#(
    parameter logic [6:0] C_DEV_ADDR = 7'h50,
    parameter int         C_FILT_LEN = 3
) (
    input  wire logic   I_clk,
    input  wire logic   I_rst_n,
    input  wire logic   I_iic_scl,
    inout  wire         IO_iic_sda,
    iic_slave_if.slave  reg_if
);

    logic                   w_scl;
    logic                   w_sda;
    logic                   w_scl_rise;
    logic                   w_scl_fall;
    logic                   w_start;
    logic                   w_stop;

    iic_state_e             r_state;
    iic_state_e             w_state_nxt;
    logic [C_BIT_CNT_W-1:0] r_bit_cnt;
    logic [7:0]             r_rx;
    logic [7:0]             r_tx;
    logic [7:0]             r_addr;
    logic [7:0]             r_wdata;
    logic                   r_mack;
    logic                   r_sda_low;
    logic                   r_we;
    logic                   r_rd;
    logic                   r_rd_d;
    logic                   r_busy;
    logic [C_DLY_W-1:0]     r_dly;

    logic                   w_byte_full;
    logic                   w_rx_state;
    logic                   w_we_req;
    logic                   w_rd_req;
    logic                   w_addr_load;
    logic                   w_drive_low;

    iic_bus_sync #(
        .C_FILT_LEN (C_FILT_LEN)
    ) u_bus_sync (
        .I_clk      (I_clk),
        .I_rst_n    (I_rst_n),
        .I_scl      (I_iic_scl),
        .I_sda      (IO_iic_sda),
        .O_scl      (w_scl),
        .O_sda      (w_sda),
        .O_scl_rise (w_scl_rise),
        .O_scl_fall (w_scl_fall),
        .O_start    (w_start),
        .O_stop     (w_stop)
    );

    assign w_byte_full = (r_bit_cnt == C_BIT_CNT_W'(C_BITS_PER_BYTE));
    assign w_rx_state  = (r_state == S_DEV_ADDR) || (r_state == S_REG_ADDR) ||
                         (r_state == S_WDATA);

    // ------------------------------------------------------------------------
    // Controller: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Controller: next state and per-byte actions. Bus conditions take
    // priority in every state; otherwise all progress happens on SCL fall.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_we_req    = 1'b0;
        w_rd_req    = 1'b0;
        w_addr_load = 1'b0;
        if (w_stop) begin
            w_state_nxt = S_IDLE;
        end else if (w_start) begin
            w_state_nxt = S_DEV_ADDR;
        end else if (w_scl_fall) begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_IDLE;
                end
                S_DEV_ADDR: begin
                    if (w_byte_full) begin
                        w_state_nxt = (r_rx[7:1] == C_DEV_ADDR) ? S_DEV_ACK : S_IDLE;
                    end
                end
                S_DEV_ACK: begin
                    // r_rx still holds the address byte; bit 0 is R/W
                    if (r_rx[0]) begin
                        w_state_nxt = S_RDATA;
                        w_rd_req    = 1'b1;
                    end else begin
                        w_state_nxt = S_REG_ADDR;
                    end
                end
                S_REG_ADDR: begin
                    if (w_byte_full) begin
                        w_state_nxt = S_REG_ACK;
                        w_addr_load = 1'b1;
                    end
                end
                S_REG_ACK: begin
                    w_state_nxt = S_WDATA;
                end
                S_WDATA: begin
                    if (w_byte_full) begin
                        w_state_nxt = S_WDATA_ACK;
                        w_we_req    = 1'b1;
                    end
                end
                S_WDATA_ACK: begin
                    w_state_nxt = S_WDATA;
                end
                S_RDATA: begin
                    if (w_byte_full) begin
                        w_state_nxt = S_RDATA_ACK;
                    end
                end
                S_RDATA_ACK: begin
                    if (!r_mack) begin
                        w_state_nxt = S_RDATA;
                        w_rd_req    = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // SDA level wanted for the bit phase the controller is now in
    always_comb begin
        w_drive_low = 1'b0;
        case (r_state)
            S_DEV_ACK, S_REG_ACK, S_WDATA_ACK: w_drive_low = 1'b1;
            S_RDATA:                           w_drive_low = ~r_tx[7];
            default:                           w_drive_low = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Bit counter and shift registers. Bits are counted on SCL rise; the
    // counter saturates at a full byte until the closing SCL fall.
    // ------------------------------------------------------------------------
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_bit_cnt <= '0;
            r_rx      <= '0;
            r_tx      <= '0;
            r_mack    <= 1'b1;
        end else begin
            if (w_start || w_stop) begin
                r_bit_cnt <= '0;
            end else if (w_scl_fall && w_byte_full) begin
                r_bit_cnt <= '0;
            end else if (w_scl_rise && (w_rx_state || (r_state == S_RDATA)) &&
                         !w_byte_full) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            if (w_scl_rise && w_rx_state) begin
                r_rx <= {r_rx[6:0], w_sda};
            end

            if (w_scl_rise && (r_state == S_RDATA_ACK)) begin
                r_mack <= w_sda;
            end

            // Read data arrives the cycle after the request; otherwise the
            // next bit moves to the MSB on each SCL fall within the byte.
            if (r_rd_d) begin
                r_tx <= reg_if.reg_rdata;
            end else if (w_scl_fall && (r_state == S_RDATA) && !w_byte_full) begin
                r_tx <= {r_tx[6:0], 1'b0};
            end
        end
    end

    // ------------------------------------------------------------------------
    // Register-side handshake
    // ------------------------------------------------------------------------
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_we    <= 1'b0;
            r_rd    <= 1'b0;
            r_rd_d  <= 1'b0;
            r_wdata <= '0;
            r_addr  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_we   <= w_we_req;
            r_rd   <= w_rd_req;
            r_rd_d <= r_rd;
            if (w_we_req) begin
                r_wdata <= r_rx;
            end
            // Increment after the write strobe, or once read data is latched;
            // 8-bit arithmetic wraps 8'hFF to 8'h00.
            if (w_addr_load) begin
                r_addr <= r_rx;
            end else if (r_we || r_rd_d) begin
                r_addr <= r_addr + 8'd1;
            end
            if (w_stop) begin
                r_busy <= 1'b0;
            end else if (w_start) begin
                r_busy <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // SDA driver. Changes are deferred C_DRIVE_DLY cycles past SCL fall so
    // the line is stable well before SCL rises again; START/STOP release at
    // once. The extra SCL-low guard keeps SDA still if SCL comes back early.
    // ------------------------------------------------------------------------
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_sda_low <= 1'b0;
            r_dly     <= '0;
        end else begin
            if (w_start || w_stop) begin
                r_sda_low <= 1'b0;
                r_dly     <= '0;
            end else if (w_scl_fall) begin
                r_dly <= C_DLY_W'(C_DRIVE_DLY);
            end else if (r_dly != '0) begin
                r_dly <= r_dly - 1'b1;
                if ((r_dly == C_DLY_W'(1)) && !w_scl) begin
                    r_sda_low <= w_drive_low;
                end
            end
        end
    end

    assign IO_iic_sda       = r_sda_low ? 1'b0 : 1'bz;

    assign reg_if.reg_addr  = r_addr;
    assign reg_if.reg_wdata = r_wdata;
    assign reg_if.reg_we    = r_we;
    assign reg_if.reg_rd    = r_rd;
    assign reg_if.busy      = r_busy;

endmodule : iic_slave
`default_nettype wire

// File: tb/tb_iic_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_iic_slave
//  Description : Directed bench for iic_slave: a bit-banged initiator drives
//                write, read, wrong-address, wrap, glitch and reset cases;
//                a register model answers reads with addr^8'hFF.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iic_slave;

    localparam int H = 20;   // SCL half period in clk cycles
    localparam int Q = 10;   // quarter bit

    logic clk = 1'b0;
    logic rst_n;
    logic scl;
    logic m_low;
    wire  sda;

    int total = 0;
    int bad   = 0;

    logic [7:0] we_addr [8];
    logic [7:0] we_data [8];
    logic [7:0] rd_addr [8];
    int         n_we   = 0;
    int         n_rd   = 0;
    int         n_both = 0;
    logic       dut_low = 1'b0;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    iic_slave_if reg_if ();

    iic_slave #(
        .C_DEV_ADDR (7'h50),
        .C_FILT_LEN (3)
    ) dut (
        .I_clk      (clk),
        .I_rst_n    (rst_n),
        .I_iic_scl  (scl),
        .IO_iic_sda (sda),
        .reg_if     (reg_if)
    );

    always #5 clk = ~clk;

    // Register model: read data valid the cycle after the request
    always @(posedge clk) begin
        if (reg_if.reg_rd) reg_if.reg_rdata <= reg_if.reg_addr ^ 8'hFF;
    end

    // Strobe and drive monitor
    always @(negedge clk) begin
        if (reg_if.reg_we) begin
            if (n_we < 8) begin
                we_addr[n_we] = reg_if.reg_addr;
                we_data[n_we] = reg_if.reg_wdata;
            end
            n_we++;
        end
        if (reg_if.reg_rd) begin
            if (n_rd < 8) rd_addr[n_rd] = reg_if.reg_addr;
            n_rd++;
        end
        if (reg_if.reg_we && reg_if.reg_rd) n_both++;
        if ((sda === 1'b0) && !m_low) dut_low = 1'b1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        n_we = 0;
        n_rd = 0;
    endtask

    task automatic bus_start();
        m_low = 1'b0;
        wait_clk(H);
        scl = 1'b1;
        wait_clk(H);
        m_low = 1'b1;
        wait_clk(H);
        scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(Q);
        m_low = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(H);
        m_low = 1'b0;
        wait_clk(H);
    endtask

    // Sends the top n bits of b; glitch_at selects a bit whose low phase
    // carries a one-cycle SCL pulse.
    task automatic send_bits(input logic [7:0] b, input int n, input int glitch_at);
        for (int i = 0; i < n; i++) begin
            wait_clk(Q);
            m_low = ~b[7-i];
            if (i == glitch_at) begin
                wait_clk(3);
                scl = 1'b1;
                wait_clk(1);
                scl = 1'b0;
                wait_clk(Q - 4);
            end else begin
                wait_clk(Q);
            end
            scl = 1'b1;
            wait_clk(H);
            scl = 1'b0;
        end
    endtask

    task automatic get_ack(output logic ack);
        wait_clk(Q);
        m_low = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        ack = (sda === 1'b0);
        wait_clk(Q);
        scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int glitch_at, output logic ack);
        send_bits(b, 8, glitch_at);
        get_ack(ack);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] b);
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            wait_clk(Q);
            m_low = 1'b0;
            wait_clk(Q);
            scl = 1'b1;
            wait_clk(Q);
            b = {b[6:0], (sda === 1'b1)};
            wait_clk(Q);
            scl = 1'b0;
        end
        wait_clk(Q);
        m_low = mack;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(H);
        scl = 1'b0;
    endtask

    initial begin
        logic       ack;
        logic [7:0] rb;

        rst_n = 1'b0;
        scl   = 1'b1;
        m_low = 1'b0;
        wait_clk(5);
        check_val("rst_addr",  reg_if.reg_addr,  8'h00);
        check_val("rst_wdata", reg_if.reg_wdata, 8'h00);
        check_val("rst_we",    reg_if.reg_we,    1'b0);
        check_val("rst_rd",    reg_if.reg_rd,    1'b0);
        check_val("rst_busy",  reg_if.busy,      1'b0);
        check_val("rst_sda",   sda,              1'b1);
        rst_n = 1'b1;
        wait_clk(10);

        // Write two bytes from register 0x10
        clear_log();
        bus_start();
        wait_clk(2);
        check_val("wr_busy", reg_if.busy, 1'b1);
        send_byte(8'hA0, -1, ack); check_val("wr_ack_dev",  ack, 1'b1);
        send_byte(8'h10, -1, ack); check_val("wr_ack_reg",  ack, 1'b1);
        send_byte(8'hA5, -1, ack); check_val("wr_ack_d0",   ack, 1'b1);
        send_byte(8'h3C, -1, ack); check_val("wr_ack_d1",   ack, 1'b1);
        bus_stop();
        check_val("wr_idle_busy", reg_if.busy, 1'b0);
        check_val("wr_n_we",  n_we, 2);
        check_val("wr_a0",    we_addr[0], 8'h10);
        check_val("wr_d0",    we_data[0], 8'hA5);
        check_val("wr_a1",    we_addr[1], 8'h11);
        check_val("wr_d1",    we_data[1], 8'h3C);
        check_val("wr_n_rd",  n_rd, 0);

        // Read two bytes from register 0x20 via repeated START
        clear_log();
        bus_start();
        send_byte(8'hA0, -1, ack); check_val("rd_ack_dev", ack, 1'b1);
        send_byte(8'h20, -1, ack); check_val("rd_ack_reg", ack, 1'b1);
        bus_start();
        send_byte(8'hA1, -1, ack); check_val("rd_ack_devr", ack, 1'b1);
        recv_byte(1'b1, rb); check_val("rd_byte0", rb, 8'hDF);
        recv_byte(1'b0, rb); check_val("rd_byte1", rb, 8'hDE);
        bus_stop();
        check_val("rd_n_rd", n_rd, 2);
        check_val("rd_a0",   rd_addr[0], 8'h20);
        check_val("rd_a1",   rd_addr[1], 8'h21);
        check_val("rd_n_we", n_we, 0);

        // Wrong device address
        clear_log();
        bus_start();
        dut_low = 1'b0;
        send_byte(8'hB0, -1, ack); check_val("wa_ack", ack, 1'b0);
        check_val("wa_sda_driven", dut_low, 1'b0);
        bus_stop();
        check_val("wa_n_we", n_we, 0);
        check_val("wa_n_rd", n_rd, 0);

        // Address wrap
        clear_log();
        bus_start();
        send_byte(8'hA0, -1, ack);
        send_byte(8'hFF, -1, ack);
        send_byte(8'h11, -1, ack);
        send_byte(8'h22, -1, ack); check_val("wrap_ack", ack, 1'b1);
        bus_stop();
        check_val("wrap_n_we", n_we, 2);
        check_val("wrap_a0",   we_addr[0], 8'hFF);
        check_val("wrap_d0",   we_data[0], 8'h11);
        check_val("wrap_a1",   we_addr[1], 8'h00);
        check_val("wrap_d1",   we_data[1], 8'h22);

        // One-cycle SCL glitch inside a data byte
        clear_log();
        bus_start();
        send_byte(8'hA0, -1, ack);
        send_byte(8'h30, -1, ack);
        send_byte(8'h5A, 3, ack); check_val("gl_ack", ack, 1'b1);
        bus_stop();
        check_val("gl_n_we", n_we, 1);
        check_val("gl_a0",   we_addr[0], 8'h30);
        check_val("gl_d0",   we_data[0], 8'h5A);

        // Reset during bit 4 of a data byte
        clear_log();
        bus_start();
        send_byte(8'hA0, -1, ack);
        send_byte(8'h40, -1, ack);
        send_bits(8'hC3, 4, -1);
        wait_clk(Q);
        rst_n = 1'b0;
        m_low = 1'b0;
        #1;
        check_val("mid_rst_sda",  sda, 1'b1);
        check_val("mid_rst_busy", reg_if.busy, 1'b0);
        check_val("mid_rst_addr", reg_if.reg_addr, 8'h00);
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(10);
        check_val("mid_rst_n_we", n_we, 0);

        // Reset while the target is holding ACK low
        bus_start();
        send_byte(8'hA0, -1, ack);
        send_bits(8'h40, 8, -1);
        m_low = 1'b0;
        wait_clk(16);
        check_val("ack_held_low", sda, 1'b0);
        rst_n = 1'b0;
        #1;
        check_val("ack_rst_release", sda, 1'b1);
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(10);

        // Full transaction after reset
        clear_log();
        bus_start();
        send_byte(8'hA0, -1, ack); check_val("post_ack_dev", ack, 1'b1);
        send_byte(8'h50, -1, ack);
        send_byte(8'h77, -1, ack); check_val("post_ack_d", ack, 1'b1);
        bus_stop();
        check_val("post_n_we", n_we, 1);
        check_val("post_a0",   we_addr[0], 8'h50);
        check_val("post_d0",   we_data[0], 8'h77);

        check_val("we_rd_overlap", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_iic_slave
`default_nettype wire
